wb_mem_master: RTL

- Pipelined-Wishbone initiator that turns single load/store requests from the CPU load/store unit into one bus cycle each.
- Drives the 64-bit shared bus that memory-mapped peripherals (timer, UART, etc.) respond on.
- Handles byte-lane placement, sel generation, load sign/zero extension, misalignment rejection and a bus timeout for unmapped addresses.
- One outstanding transaction at a time.

---
 rtl/wb_mem_master.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/wb_mem_master.sv
// Pipelined Wishbone initiator for single load/store requests.
// Places byte lanes, extends loads, rejects misalignment, times out.
module wb_mem_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [63:0] i_req_addr,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [63:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [63:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [63:0] o_wb_adr,
  output logic [63:0] o_wb_dat,
  input  logic [63:0] i_wb_dat,
  output logic        o_wb_we,
  output logic [7:0]  o_wb_sel,
  output logic        o_wb_stb,
  output logic        o_wb_cyc,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STB,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;

  logic        cyc_d, stb_d, we_d;
  logic [7:0]  sel_d;
  logic [63:0] adr_d, dat_d;
  logic        rsp_valid_d, rsp_err_d;
  logic [63:0] rdata_d;

  logic        stall;
  logic        expired;
  logic [63:0] load_data;

  function automatic logic misaligned(
    input logic [2:0] a,
    input logic [1:0] sz
  );
    logic m;
    unique case (sz)
      2'd0:    m = 1'b0;
      2'd1:    m = a[0];
      2'd2:    m = |a[1:0];
      default: m = |a[2:0];
    endcase
    return m;
  endfunction

  function automatic logic [7:0] lane_sel(
    input logic [2:0] off,
    input logic [1:0] sz
  );
    logic [7:0] s;
    unique case (sz)
      2'd0:    s = 8'h01 << off;
      2'd1:    s = 8'h03 << off;
      2'd2:    s = 8'h0F << off;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  function automatic logic [63:0] extend(
    input logic [63:0] d,
    input logic [2:0]  off,
    input logic [1:0]  sz,
    input logic        sg
  );
    logic [63:0] r;
    logic [63:0] x;
    r = d >> {off, 3'b000};
    unique case (sz)
      2'd0:    x = {{56{sg & r[7]}}, r[7:0]};
      2'd1:    x = {{48{sg & r[15]}}, r[15:0]};
      2'd2:    x = {{32{sg & r[31]}}, r[31:0]};
      default: x = r;
    endcase
    return x;
  endfunction

  assign o_req_ready = (state_q == S_IDLE);
  assign stall       = (i_wb_stall == 1'b1);
  assign expired     = (cnt_q == TO_LAST);
  assign load_data   = extend(i_wb_dat, off_q, size_q, sgn_q);

  // State, bus and response registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_sel    <= '0;
      o_wb_adr    <= '0;
      o_wb_dat    <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_rdata <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      o_wb_cyc    <= cyc_d;
      o_wb_stb    <= stb_d;
      o_wb_we     <= we_d;
      o_wb_sel    <= sel_d;
      o_wb_adr    <= adr_d;
      o_wb_dat    <= dat_d;
      o_rsp_valid <= rsp_valid_d;
      o_rsp_err   <= rsp_err_d;
      o_rsp_rdata <= rdata_d;
    end
  end

  // Next-state, bus control and response generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = o_wb_cyc ? cnt_q + 16'd1 : cnt_q;
    off_d       = off_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    cyc_d       = o_wb_cyc;
    stb_d       = o_wb_stb;
    we_d        = o_wb_we;
    sel_d       = o_wb_sel;
    adr_d       = o_wb_adr;
    dat_d       = o_wb_dat;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rdata_d     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          cnt_d = '0;
          if (misaligned(i_req_addr[2:0], i_req_size)) begin
            state_d     = S_ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = S_STB;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = i_req_we;
            sel_d   = lane_sel(i_req_addr[2:0], i_req_size);
            adr_d   = {i_req_addr[63:3], 3'b000};
            dat_d   = i_req_wdata << {i_req_addr[2:0], 3'b000};
            off_d   = i_req_addr[2:0];
            size_d  = i_req_size;
            sgn_d   = i_req_signed;
          end
        end
      end

      S_STB: begin
        if (!stall && i_wb_ack) begin
          state_d     = S_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rdata_d     = o_wb_we ? 64'd0 : load_data;
        end else if (expired) begin
          state_d     = S_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (!stall) begin
          state_d = S_WAIT;
          stb_d   = 1'b0;
        end
      end

      S_WAIT: begin
        if (i_wb_ack) begin
          state_d     = S_RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rdata_d     = o_wb_we ? 64'd0 : load_data;
        end else if (expired) begin
          state_d     = S_RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end

      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
